// File: rtl/alu_mp_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_mp_seq : issues one K*N-bit operation to a shared N-bit alu, one limb   |
// |              per cycle LSB first, chaining carry/borrow into a wide result. |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module alu_mp_seq #(
  parameter int N    = 8,
  parameter int K    = 4,
  parameter int AC_N = 3,
  parameter logic [AC_N-1:0] AC_AD = AC_N'(0),
  parameter logic [AC_N-1:0] AC_SB = AC_N'(1),
  parameter logic [AC_N-1:0] AC_AN = AC_N'(2),
  parameter logic [AC_N-1:0] AC_OR = AC_N'(3)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [N*K-1:0]  a,
  input  logic [N*K-1:0]  b,
  input  logic            cin,
  output logic            busy,
  output logic            done,
  output logic [N*K-1:0]  result,
  output logic            cout,
  output logic            zero,
  output logic [AC_N-1:0] alu_cs,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic            alu_cin,
  input  logic [N-1:0]    alu_s,
  input  logic            alu_zero,
  input  logic            alu_cout
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [2:0] C_OP_ADD = 3'd0;
  localparam logic [2:0] C_OP_ADC = 3'd1;
  localparam logic [2:0] C_OP_SUB = 3'd2;
  localparam logic [2:0] C_OP_SBB = 3'd3;
  localparam logic [2:0] C_OP_OR  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, sh_q, result_q;
  logic [2:0]      op_q;
  logic            cin_q, carry_q, zacc_q, cout_q, zero_q;
  logic [IW-1:0]   idx_q;

  logic            w_accept, w_last, w_arith, w_sub;
  logic [W-1:0]    w_sh_next;

  assign w_accept = start & (state_q != S_RUN);
  assign w_last   = (idx_q == IW'(K - 1));
  assign w_arith  = (op_q <= C_OP_SBB);
  assign w_sub    = (op_q == C_OP_SUB) | (op_q == C_OP_SBB);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_RUN;
      S_RUN:   if (w_last) state_d = S_DONE;
      S_DONE:  state_d = w_accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_sh_next = sh_q;
    w_sh_next[idx_q*N +: N] = alu_s;
  end

  always_comb begin
    alu_cs = AC_AN;
    if (w_arith)             alu_cs = w_sub ? AC_SB : AC_AD;
    else if (op_q == C_OP_OR) alu_cs = AC_OR;
  end

  // The alu reports borrow on AC_SB, so subtract chains feed back its inverse.
  always_comb begin
    alu_cin = 1'b0;
    if (idx_q == '0) begin
      case (op_q)
        C_OP_ADC: alu_cin = cin_q;
        C_OP_SUB: alu_cin = 1'b1;
        C_OP_SBB: alu_cin = ~cin_q;
        default:  alu_cin = 1'b0;
      endcase
    end else if (w_arith) begin
      alu_cin = w_sub ? ~carry_q : carry_q;
    end
  end

  assign alu_a  = a_q[idx_q*N +: N];
  assign alu_b  = b_q[idx_q*N +: N];
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= C_OP_ADD;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b1;
      sh_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        a_q    <= a;
        b_q    <= b;
        op_q   <= op;
        cin_q  <= cin;
        idx_q  <= '0;
        zacc_q <= 1'b1;
        sh_q   <= '0;
      end else if (state_q == S_RUN) begin
        sh_q    <= w_sh_next;
        zacc_q  <= zacc_q & alu_zero;
        carry_q <= alu_cout;
        idx_q   <= w_last ? '0 : idx_q + IW'(1);
        // Held outputs change only when the final limb lands.
        if (w_last) begin
          result_q <= w_sh_next;
          cout_q   <= w_arith & alu_cout;
          zero_q   <= zacc_q & alu_zero;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mp_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_mp_seq : random + directed bench with a wide-arithmetic reference    |
// |                 model, a behavioural alu and a result scoreboard.           |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_alu_mp_seq;

  localparam int N    = 8;
  localparam int K    = 4;
  localparam int W    = N * K;
  localparam int AC_N = 3;
  localparam logic [AC_N-1:0] AC_AD = 3'd0;
  localparam logic [AC_N-1:0] AC_SB = 3'd1;
  localparam logic [AC_N-1:0] AC_AN = 3'd2;
  localparam logic [AC_N-1:0] AC_OR = 3'd3;

  logic            clk = 1'b0;
  logic            rst, start, cin;
  logic [2:0]      op;
  logic [W-1:0]    a, b;
  logic            busy, done, cout, zero;
  logic [W-1:0]    result;
  logic [AC_N-1:0] alu_cs;
  logic [N-1:0]    alu_a, alu_b, alu_s;
  logic            alu_cin, alu_zero, alu_cout;

  alu_mp_seq #(.N(N), .K(K), .AC_N(AC_N), .AC_AD(AC_AD), .AC_SB(AC_SB),
               .AC_AN(AC_AN), .AC_OR(AC_OR)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .alu_cs(alu_cs), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_s(alu_s), .alu_zero(alu_zero), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural single-limb alu; carry_out is a borrow on AC_SB.
  logic [N:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (alu_cs)
      AC_AD:   alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
      AC_SB:   begin
                 alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, alu_cin};
                 alu_t[N] = ~alu_t[N];
               end
      AC_AN:   alu_t = {1'b0, alu_a & alu_b};
      AC_OR:   alu_t = {1'b0, alu_a | alu_b};
      default: alu_t = '0;
    endcase
  end
  assign alu_s    = alu_t[N-1:0];
  assign alu_cout = alu_t[N];
  assign alu_zero = (alu_s == '0);

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: {zero, cout, result} from whole-word arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic c);
    longint unsigned ux, uy, r;
    logic co;
    ux = 64'(x); uy = 64'(y); co = 1'b0;
    case (o)
      3'd0:    begin r = ux + uy;                co = r[W]; end
      3'd1:    begin r = ux + uy + 64'(c);       co = r[W]; end
      3'd2:    begin r = ux - uy;                co = (ux < uy); end
      3'd3:    begin r = ux - uy - 64'(c);       co = (ux < uy + 64'(c)); end
      3'd5:    r = ux | uy;
      default: r = ux & uy;
    endcase
    return {(r[W-1:0] == '0), co, r[W-1:0]};
  endfunction

  function automatic logic [AC_N-1:0] ref_cs(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return AC_AD;
      3'd2, 3'd3: return AC_SB;
      3'd5:       return AC_OR;
      default:    return AC_AN;
    endcase
  endfunction

  // Carry (or not-borrow) entering limb i, from the low i limbs of the operands.
  function automatic logic ref_cin(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic c, input int i);
    longint unsigned m, lx, ly, s;
    m  = (64'd1 << (N * i)) - 64'd1;
    lx = 64'(x) & m;
    ly = 64'(y) & m;
    case (o)
      3'd0:    begin s = (lx + ly) >> (N * i);          return s[0]; end
      3'd1:    begin s = (lx + ly + 64'(c)) >> (N * i); return s[0]; end
      3'd2:    return !(lx < ly);
      3'd3:    return !(lx < ly + 64'(c));
      default: return 1'b0;
    endcase
  endfunction

  // Bench-side view of the transaction protocol.
  int              cyc = 0;
  int              m_e = 0;
  logic            m_active = 1'b0;
  logic [2:0]      cur_op = '0;
  logic [W-1:0]    cur_a = '0, cur_b = '0;
  logic            cur_cin = 1'b0;
  logic [W+1:0]    cur_exp = '0;
  logic [W+1:0]    held = {1'b1, 1'b0, {W{1'b0}}};
  logic [W+1:0]    exp_q[$];
  logic            m_busy;

  assign m_busy = m_active && (cyc >= m_e) && (cyc < m_e + K);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active <= 1'b0;
      exp_q.delete();
      held <= {1'b1, 1'b0, {W{1'b0}}};
    end else begin
      if (m_active && cyc == m_e + K - 1) held <= cur_exp;
      if (start && !m_busy) begin
        m_e      <= cyc + 1;
        m_active <= 1'b1;
        cur_op   <= op;
        cur_a    <= a;
        cur_b    <= b;
        cur_cin  <= cin;
        cur_exp  <= ref_op(op, a, b, cin);
        exp_q.push_back(ref_op(op, a, b, cin));
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic [W+1:0] e;
      logic         exp_done;
      int           i;
      exp_done = m_active && (cyc == m_e + K);
      check("busy", busy === m_busy, 64'(busy), 64'(m_busy));
      check("done", done === exp_done, 64'(done), 64'(exp_done));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1'b0, 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {zero, cout, result} === e, 64'({zero, cout, result}), 64'(e));
        end
      end else begin
        check("hold", {zero, cout, result} === held, 64'({zero, cout, result}), 64'(held));
      end
      if (m_busy) begin
        logic [AC_N+2*N:0] le;
        i  = cyc - m_e;
        le = {ref_cs(cur_op), cur_a[i*N +: N], cur_b[i*N +: N],
              ref_cin(cur_op, cur_a, cur_b, cur_cin, i)};
        check("limb", {alu_cs, alu_a, alu_b, alu_cin} === le,
              64'({alu_cs, alu_a, alu_b, alu_cin}), 64'(le));
      end
    end
  end

  task automatic check_reset();
    check("rst_busy",   busy === 1'b0,     64'(busy),   64'd0);
    check("rst_done",   done === 1'b0,     64'(done),   64'd0);
    check("rst_result", result === '0,     64'(result), 64'd0);
    check("rst_cout",   cout === 1'b0,     64'(cout),   64'd0);
    check("rst_zero",   zero === 1'b1,     64'(zero),   64'd1);
    check("rst_alu_cs", alu_cs === AC_AD,  64'(alu_cs), 64'(AC_AD));
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic c);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (K + 1) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset();

    issue(3'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    issue(3'd2, 32'h0000_0000, 32'h0000_0001, 1'b0);
    issue(3'd2, 32'h0001_0000, 32'h0000_0001, 1'b0);
    issue(3'd1, 32'h0000_0001, 32'h0000_0001, 1'b1);
    issue(3'd3, 32'h0000_0005, 32'h0000_0002, 1'b1);
    issue(3'd4, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0);
    issue(3'd5, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0);
    issue(3'd6, 32'h1234_5678, 32'hFF00_FF00, 1'b1);
    issue(3'd7, 32'h8000_0001, 32'h8000_0001, 1'b1);

    // start held high with operands churning: one accept per busy window.
    op = 3'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    for (int n = 0; n < 3 * (K + 1); n++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 3)); cin = 1'($urandom);
    end
    start = 1'b0;
    repeat (K + 2) @(negedge clk);

    // Abort during limb 2.
    op = 3'd0; a = 32'hDEAD_BEEF; b = 32'h0101_0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset();
    repeat (K + 2) @(negedge clk);

    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom_range(0, 7));
      cin   = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = a; end
        1:       begin a = '1; b = 32'($urandom_range(0, 3)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    repeat (K + 2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
